// File: rtl/perip_pkg.sv
// Shared encodings and helpers for the peripheral-bus initiator.
package perip_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RSP     = 2'd2
  } state_e;

  // Reserved size (2'b11) is treated as misaligned so it takes the error path.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    misaligned = 1'b0;
      SZ_H:    misaligned = off[0];
      SZ_W:    misaligned = |off;
      default: misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/perip_lane_align.sv
// Byte-lane steering: store mask/replication on the way out, load
// extraction and sign/zero extension on the way back.
module perip_lane_align
  import perip_pkg::*;
(
  input  logic [1:0]  st_size_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_wdata_i,
  output logic [3:0]  mask_o,
  output logic [31:0] wdata_o,
  input  logic [1:0]  ld_size_i,
  input  logic [1:0]  ld_off_i,
  input  logic        ld_unsigned_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] rdata_o
);

  logic [31:0] shifted;

  always_comb begin
    mask_o  = 4'b1111;
    wdata_o = st_wdata_i;
    case (st_size_i)
      SZ_B: begin
        mask_o  = 4'b0001 << st_off_i;
        wdata_o = {4{st_wdata_i[7:0]}};
      end
      SZ_H: begin
        mask_o  = st_off_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{st_wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  assign shifted = rdata_i >> {ld_off_i, 3'b000};

  always_comb begin
    rdata_o = shifted;
    case (ld_size_i)
      SZ_B:    rdata_o = {{24{~ld_unsigned_i & shifted[7]}}, shifted[7:0]};
      SZ_H:    rdata_o = {{16{~ld_unsigned_i & shifted[15]}}, shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/perip_initiator.sv
// Load/store initiator for the fixed-latency peripheral bus: one access in
// flight, tagged valid/ready response with misalignment reported as error.
module perip_initiator
  import perip_pkg::*;
#(
  parameter int RD_LATENCY = 1,
  parameter int TAG_W      = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             rsp_err,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [31:0]      perip_waddr,
  output logic [31:0]      perip_wdata,
  output logic             perip_wen,
  output logic [3:0]       perip_mask,
  output logic [31:0]      perip_raddr,
  input  logic [31:0]      perip_rdata
);

  localparam int CW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q;
  logic [31:0]       rsp_data_q, raddr_q;
  logic              rsp_err_q;
  logic [TAG_W-1:0]  rsp_tag_q;
  logic [1:0]        ld_size_q, ld_off_q;
  logic              ld_uns_q;

  logic              accept, req_err, ld_issue;
  logic [31:0]       aligned, ld_data;

  assign aligned   = {req_addr[31:2], 2'b00};
  assign req_err   = misaligned(req_size, req_addr[1:0]);
  assign req_ready = (state_q == IDLE) | ((state_q == RSP) & rsp_ready);
  assign accept    = req_valid & req_ready;
  assign ld_issue  = accept & ~req_we & ~req_err;

  assign perip_wen   = accept & req_we & ~req_err;
  assign perip_waddr = aligned;
  // Read address only moves on an actual load issue, so it stays stable
  // across RD_WAIT regardless of what the sender presents meanwhile.
  assign perip_raddr = ld_issue ? aligned : raddr_q;

  assign rsp_valid = (state_q == RSP);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_tag   = rsp_tag_q;

  perip_lane_align u_align (
    .st_size_i     (req_size),
    .st_off_i      (req_addr[1:0]),
    .st_wdata_i    (req_wdata),
    .mask_o        (perip_mask),
    .wdata_o       (perip_wdata),
    .ld_size_i     (ld_size_q),
    .ld_off_i      (ld_off_q),
    .ld_unsigned_i (ld_uns_q),
    .rdata_i       (perip_rdata),
    .rdata_o       (ld_data)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, RSP: begin
        if (state_q == RSP && rsp_ready) state_d = IDLE;
        if (accept) state_d = (req_we | req_err) ? RSP : RD_WAIT;
      end
      RD_WAIT: if (cnt_q == '0) state_d = RSP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      rsp_tag_q  <= '0;
      raddr_q    <= '0;
      ld_size_q  <= SZ_B;
      ld_off_q   <= 2'b00;
      ld_uns_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rsp_tag_q  <= req_tag;
        rsp_err_q  <= req_err;
        rsp_data_q <= '0;
        ld_size_q  <= req_size;
        ld_off_q   <= req_addr[1:0];
        ld_uns_q   <= req_unsigned;
        if (ld_issue) begin
          raddr_q <= aligned;
          cnt_q   <= CW'(RD_LATENCY - 1);
        end
      end else if (state_q == RD_WAIT) begin
        if (cnt_q == '0) rsp_data_q <= ld_data;
        else             cnt_q      <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_perip_initiator.sv
// Randomized bench: byte-addressed reference memory predicts bus strobes,
// load results and response timing; a second instance covers RD_LATENCY=3.
module tb_perip_initiator;

  localparam int LAT = 1;
  localparam int TW  = 5;
  localparam int N   = 70;
  localparam int K   = 40;

  typedef struct {
    logic          we;
    logic [31:0]   addr;
    logic [31:0]   wd;
    logic [1:0]    size;
    logic          uns;
    logic [TW-1:0] tag;
    int            stall;
  } req_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          req_valid, req_ready, req_we, req_unsigned, rsp_valid, rsp_ready, rsp_err, perip_wen;
  logic [31:0]   req_addr, req_wdata, rsp_data, perip_waddr, perip_wdata, perip_raddr, perip_rdata;
  logic [1:0]    req_size;
  logic [TW-1:0] req_tag, rsp_tag;
  logic [3:0]    perip_mask;

  logic          r3_valid, r3_ready, r3_we, r3_uns, r3_rsp_valid, r3_rsp_err, r3_wen;
  logic [31:0]   r3_addr, r3_wdata, r3_rsp_data, r3_waddr, r3_pwdata, r3_raddr, r3_rdata;
  logic [1:0]    r3_size;
  logic [TW-1:0] r3_tag, r3_rsp_tag;
  logic [3:0]    r3_mask;

  perip_initiator #(.RD_LATENCY(LAT), .TAG_W(TW)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .rsp_tag(rsp_tag), .perip_waddr(perip_waddr), .perip_wdata(perip_wdata),
    .perip_wen(perip_wen), .perip_mask(perip_mask), .perip_raddr(perip_raddr),
    .perip_rdata(perip_rdata)
  );

  perip_initiator #(.RD_LATENCY(3), .TAG_W(TW)) u_dut3 (
    .clk(clk), .rst(rst),
    .req_valid(r3_valid), .req_ready(r3_ready), .req_we(r3_we), .req_addr(r3_addr),
    .req_wdata(r3_wdata), .req_size(r3_size), .req_unsigned(r3_uns), .req_tag(r3_tag),
    .rsp_valid(r3_rsp_valid), .rsp_ready(1'b1), .rsp_data(r3_rsp_data), .rsp_err(r3_rsp_err),
    .rsp_tag(r3_rsp_tag), .perip_waddr(r3_waddr), .perip_wdata(r3_pwdata),
    .perip_wen(r3_wen), .perip_mask(r3_mask), .perip_raddr(r3_raddr),
    .perip_rdata(r3_rdata)
  );

  // Bus responder: 16-word memory, read data delayed LAT cycles after address.
  logic [31:0] bus_mem [16];
  logic [31:0] rpipe [LAT];
  logic [31:0] p3 [3];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) bus_mem[i] <= '0;
      for (int i = 0; i < LAT; i++) rpipe[i] <= '0;
      for (int i = 0; i < 3; i++) p3[i] <= '0;
    end else begin
      if (perip_wen)
        for (int b = 0; b < 4; b++)
          if (perip_mask[b]) bus_mem[perip_waddr[5:2]][8*b +: 8] <= perip_wdata[8*b +: 8];
      rpipe[0] <= bus_mem[perip_raddr[5:2]];
      for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
      p3[0] <= r3_raddr ^ 32'hF0F0_0000;
      p3[1] <= p3[0];
      p3[2] <= p3[1];
    end
  end
  assign perip_rdata = rpipe[LAT-1];
  assign r3_rdata    = p3[2];

  logic [7:0] ref_mem [64];
  req_t reqs [N];
  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h want %h @%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input req_t r);
    req_valid    = 1'b1;
    req_we       = r.we;
    req_addr     = r.addr;
    req_wdata    = r.wd;
    req_size     = r.size;
    req_unsigned = r.uns;
    req_tag      = r.tag;
  endtask

  task automatic run(input int i);
    req_t r;
    int n, off, cyc;
    logic err;
    logic [31:0] exp_d, exp_w, v;
    logic [3:0] exp_m;
    r   = reqs[i];
    n   = 1 << r.size;
    off = int'(r.addr[1:0]);
    err = (r.size == 2'b11) || (off % n != 0);
    drive(r);
    #1;
    cyc = 0;
    while (!req_ready && cyc < 20) begin @(negedge clk); #1; cyc++; end
    chk("req_ready", req_ready, 1);
    chk("wen", perip_wen, r.we & ~err);
    exp_d = '0;
    if (r.we && !err) begin
      exp_m = 4'(((1 << n) - 1) << off);
      for (int b = 0; b < 4; b++) exp_w[8*b +: 8] = r.wd[8*(b % n) +: 8];
      chk("waddr", perip_waddr, r.addr & ~32'h3);
      chk("mask", perip_mask, exp_m);
      chk("wdata", perip_wdata, exp_w);
      for (int k = 0; k < n; k++) ref_mem[int'(r.addr[5:0]) + k] = r.wd[8*k +: 8];
    end
    if (!r.we && !err) begin
      chk("raddr", perip_raddr, r.addr & ~32'h3);
      v = '0;
      for (int k = 0; k < n; k++) v[8*k +: 8] = ref_mem[int'(r.addr[5:0]) + k];
      if (!r.uns && v[8*n-1])
        for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
      exp_d = v;
    end
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk("wen_1cyc", perip_wen, 0);
    cyc = 1;
    while (!rsp_valid && cyc < 20) begin @(negedge clk); #1; cyc++; end
    chk("latency", cyc, (r.we || err) ? 1 : LAT + 1);
    chk("rsp_data", rsp_data, exp_d);
    chk("rsp_err", rsp_err, err);
    chk("rsp_tag", rsp_tag, r.tag);
    if (r.stall > 0) begin
      rsp_ready = 1'b0;
      if (i + 1 < N) drive(reqs[i+1]);
      for (int s = 0; s < r.stall; s++) begin
        @(negedge clk); #1;
        chk("stall_valid", rsp_valid, 1);
        chk("stall_rdy", req_ready, 0);
        chk("stall_data", rsp_data, exp_d);
        chk("stall_err", rsp_err, err);
        chk("stall_tag", rsp_tag, r.tag);
      end
      rsp_ready = 1'b1;
    end
  endtask

  function automatic req_t mk(input logic we, input logic [31:0] a, input logic [31:0] d,
                              input logic [1:0] s, input logic u, input logic [TW-1:0] t, input int st);
    req_t r;
    r.we = we; r.addr = a; r.wd = d; r.size = s; r.uns = u; r.tag = t; r.stall = st;
    return r;
  endfunction

  initial begin
    int cyc, n;
    rst = 1'b1; rsp_ready = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_size = 2'b00; req_unsigned = 1'b0; req_tag = '0;
    r3_valid = 1'b0; r3_we = 1'b0; r3_addr = '0; r3_wdata = '0; r3_size = 2'b00;
    r3_uns = 1'b0; r3_tag = '0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;

    reqs[0] = mk(1'b1, 32'h0000_1000, 32'h8001_1234, 2'b10, 1'b0, 5'd1, 0);
    reqs[1] = mk(1'b0, 32'h0000_1002, 32'h0,         2'b01, 1'b0, 5'd2, 0);
    reqs[2] = mk(1'b0, 32'h0000_1002, 32'h0,         2'b01, 1'b1, 5'd3, 0);
    reqs[3] = mk(1'b0, 32'h0000_1003, 32'h0,         2'b00, 1'b0, 5'd4, 0);
    reqs[4] = mk(1'b1, 32'h0000_1001, 32'h0000_00AB, 2'b00, 1'b0, 5'd5, 0);
    reqs[5] = mk(1'b0, 32'h0000_1002, 32'h0,         2'b10, 1'b0, 5'd6, 3);
    reqs[6] = mk(1'b0, 32'h0000_1000, 32'h0,         2'b10, 1'b0, 5'd7, 0);
    for (int i = 7; i < N; i++) begin
      reqs[i] = mk($urandom_range(0, 1) == 1, 32'h1000 + $urandom_range(0, 63), $urandom,
                   ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2)),
                   $urandom_range(0, 1) == 1, TW'($urandom), 0);
      n = 1 << reqs[i].size;
      if (reqs[i].size != 2'b11 && $urandom_range(0, 4) != 0)
        reqs[i].addr = reqs[i].addr & ~32'(n - 1);
      if ($urandom_range(0, 3) == 0) reqs[i].stall = $urandom_range(1, 3);
    end
    reqs[K-1].stall = 0;
    reqs[N-1].stall = 0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", rsp_valid, 0);
    rst = 1'b0;
    #1;
    chk("rst_ready", req_ready, 1);
    chk("rst_data", rsp_data, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_tag", rsp_tag, 0);
    chk("rst_wen", perip_wen, 0);
    chk("rst_raddr", perip_raddr, 0);

    for (int i = 0; i < K; i++) run(i);

    // Reset pulse while a load waits on the bus.
    @(negedge clk);
    drive(mk(1'b0, 32'h0000_1008, 32'h0, 2'b10, 1'b0, 5'd9, 0));
    #1;
    chk("rw_accept", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk("rw_wait", rsp_valid, 0);
    rst = 1'b1;
    #1;
    chk("rw_rstv", rsp_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
    repeat (3) begin
      @(negedge clk); #1;
      chk("rw_norsp", rsp_valid, 0);
      chk("rw_idle", req_ready, 1);
    end

    for (int i = K; i < N; i++) run(i);

    // Longer-latency build: load response must appear at T+4.
    @(negedge clk);
    r3_we = 1'b0; r3_addr = 32'h0000_1004; r3_size = 2'b10; r3_uns = 1'b0; r3_tag = 5'h1B;
    r3_valid = 1'b1;
    #1;
    chk("l3_ready", r3_ready, 1);
    @(negedge clk);
    r3_valid = 1'b0;
    #1;
    cyc = 1;
    while (!r3_rsp_valid && cyc < 20) begin @(negedge clk); #1; cyc++; end
    chk("l3_latency", cyc, 4);
    chk("l3_data", r3_rsp_data, 32'hF0F0_1004);
    chk("l3_err", r3_rsp_err, 0);
    chk("l3_tag", r3_rsp_tag, 5'h1B);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
